// File: rtl/alu_seq_exec_if.sv
// Valid/ready bundle for the sequential ALU execute stage:
// operands and op select in, registered result and compare flags out.
interface alu_seq_exec_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [5:0]         op_onehot;
    logic [WIDTH-1:0]   data_operandA;
    logic [WIDTH-1:0]   data_operandB;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_result;
    logic               isNotEqual;
    logic               isLessThan;
    logic               overflow;

    modport master (
        output in_valid, op_onehot, data_operandA, data_operandB,
        output ctrl_shiftamt, out_ready,
        input  in_ready, out_valid, data_result,
        input  isNotEqual, isLessThan, overflow
    );

    modport slave (
        input  in_valid, op_onehot, data_operandA, data_operandB,
        input  ctrl_shiftamt, out_ready,
        output in_ready, out_valid, data_result,
        output isNotEqual, isLessThan, overflow
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Execute stage: single-cycle add/sub/and/or, bit-serial sll/sra,
// registered result and signed compare flags behind valid/ready.
module alu_seq_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic          clock,
    input logic          reset,
    alu_seq_exec_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, stateNext;
    logic [WIDTH-1:0]   acc, accNext;
    logic [SHAMT_W-1:0] cnt, cntNext;
    logic               arith, arithNext;
    logic               ne, neNext;
    logic               lt, ltNext;
    logic               ovf, ovfNext;

    logic [5:0]       opLow;
    logic [WIDTH-1:0] opA, opB, sum, diff;
    logic             ovfAdd, ovfSub;

    assign opA = bus.data_operandA;
    assign opB = bus.data_operandB;

    // Isolate the lowest set bit so multi-hot selects resolve by priority.
    assign opLow = bus.op_onehot & (~bus.op_onehot + 6'd1);

    assign sum    = opA + opB;
    assign diff   = opA - opB;
    assign ovfAdd = (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]);
    assign ovfSub = (opA[MSB] != opB[MSB]) && (diff[MSB] != opA[MSB]);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            arith <= 1'b0;
            ne    <= 1'b0;
            lt    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= stateNext;
            acc   <= accNext;
            cnt   <= cntNext;
            arith <= arithNext;
            ne    <= neNext;
            lt    <= ltNext;
            ovf   <= ovfNext;
        end
    end

    always_comb begin
        stateNext = state;
        accNext   = acc;
        cntNext   = cnt;
        arithNext = arith;
        neNext    = ne;
        ltNext    = lt;
        ovfNext   = ovf;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    neNext    = (opA != opB);
                    // Sign of A-B corrected by its overflow gives signed A<B.
                    ltNext    = diff[MSB] ^ ovfSub;
                    ovfNext   = 1'b0;
                    accNext   = '0;
                    stateNext = DONE;
                    unique case (1'b1)
                        opLow[0]: begin
                            accNext = sum;
                            ovfNext = ovfAdd;
                        end
                        opLow[1]: begin
                            accNext = diff;
                            ovfNext = ovfSub;
                        end
                        opLow[2]: accNext = opA & opB;
                        opLow[3]: accNext = opA | opB;
                        opLow[4], opLow[5]: begin
                            accNext   = opA;
                            arithNext = opLow[5];
                            cntNext   = bus.ctrl_shiftamt;
                            if (bus.ctrl_shiftamt != '0) begin
                                stateNext = SHIFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                if (arith) begin
                    accNext = {acc[MSB], acc[MSB:1]};
                end else begin
                    accNext = {acc[MSB-1:0], 1'b0};
                end
                cntNext = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.data_result = acc;
    assign bus.isNotEqual  = ne;
    assign bus.isLessThan  = lt;
    assign bus.overflow    = ovf;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: directed ops push expectations,
// an independent monitor compares every presented result.
module tb_alu_seq_exec;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    alu_seq_exec_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // edges: clock edges from the accept edge to the edge raising out_valid
    typedef struct {
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ovf;
        int          edges;
        int          t0;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   prevValid = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Retire the expectation on the handshake edge.
    always @(posedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready && sb.size() > 0)
            void'(sb.pop_front());
    end

    always @(negedge clock) begin
        if (reset) begin
            prevValid = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    if (!prevValid) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious out_valid: got 1 expected 0");
                    end
                end else begin
                    mon = sb[0];
                    if (!prevValid)
                        chk({mon.name, " latency"}, 32'(cyc - mon.t0),
                            32'(mon.edges));
                    chk({mon.name, " result"}, bus.data_result, mon.res);
                    chk({mon.name, " isNotEqual"}, 32'(bus.isNotEqual),
                        32'(mon.ne));
                    chk({mon.name, " isLessThan"}, 32'(bus.isLessThan),
                        32'(mon.lt));
                    chk({mon.name, " overflow"}, 32'(bus.overflow),
                        32'(mon.ovf));
                end
            end
            prevValid = bus.out_valid;
        end
    end

    task automatic drive(string name, logic [5:0] op, logic [31:0] a,
                         logic [31:0] b, logic [4:0] sh, bit push,
                         logic [31:0] res, logic ne, logic lt, logic ovf,
                         int edges);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.op_onehot     = op;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_shiftamt = sh;
        bus.in_valid      = 1'b1;
        if (push) sb.push_back('{res, ne, lt, ovf, edges, cyc + 1, name});
        @(negedge clock);
        // Scramble inputs to show they were captured at the accept edge.
        bus.in_valid      = 1'b0;
        bus.op_onehot     = 6'h3f;
        bus.data_operandA = ~a;
        bus.data_operandB = ~b;
        bus.ctrl_shiftamt = ~sh;
    endtask

    task automatic waitResult(string name);
        int   n = 0;
        logic busy = 1'b0;
        while (!bus.out_valid && n < 100) begin
            busy |= bus.in_ready;
            @(negedge clock);
            n++;
        end
        busy |= bus.in_ready;
        chk({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, " in_ready low"}, 32'(busy), 32'd0);
        if (bus.out_ready) @(negedge clock);
    endtask

    task automatic runOp(string name, logic [5:0] op, logic [31:0] a,
                         logic [31:0] b, logic [4:0] sh, logic [31:0] res,
                         logic ne, logic lt, logic ovf, int edges);
        drive(name, op, a, b, sh, 1'b1, res, ne, lt, ovf, edges);
        waitResult(name);
    endtask

    initial begin
        bus.in_valid      = 1'b0;
        bus.op_onehot     = '0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_shiftamt = '0;
        bus.out_ready     = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset result", bus.data_result, 32'd0);
        chk("reset flags", {29'd0, bus.isNotEqual, bus.isLessThan,
            bus.overflow}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        runOp("add ovf", 6'b000001, 32'h7FFFFFFF, 32'h00000001, 5'd0,
              32'h80000000, 1, 0, 1, 0);
        runOp("sub ovf", 6'b000010, 32'h80000000, 32'h00000001, 5'd0,
              32'h7FFFFFFF, 1, 1, 1, 0);
        runOp("sub ovf pos", 6'b000010, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,
              32'h80000000, 1, 0, 1, 0);
        runOp("sra 4", 6'b100000, 32'hF0000000, 32'h00000000, 5'd4,
              32'hFF000000, 1, 1, 0, 4);
        runOp("sll 31", 6'b010000, 32'h00000001, 32'h00000000, 5'd31,
              32'h80000000, 1, 0, 0, 31);
        runOp("sra 31", 6'b100000, 32'h80000000, 32'h00000000, 5'd31,
              32'hFFFFFFFF, 1, 1, 0, 31);
        runOp("or", 6'b001000, 32'h0000F0F0, 32'h0F0F0000, 5'd0,
              32'h0F0FF0F0, 1, 1, 0, 0);

        // Result must hold under a 5-cycle downstream stall.
        bus.out_ready = 1'b0;
        runOp("and stall", 6'b000100, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0,
              32'h0F000F00, 1, 1, 0, 0);
        repeat (5) begin
            chk("stall in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("release out_valid", 32'(bus.out_valid), 32'd0);
        chk("release in_ready", 32'(bus.in_ready), 32'd1);
        chk("release hold", bus.data_result, 32'h0F000F00);

        // Abandon a long shift with reset.
        drive("sll abort", 6'b010000, 32'h00000001, 32'h00000002, 5'd20,
              1'b0, 32'd0, 0, 0, 0, 0);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort result", bus.data_result, 32'd0);
        chk("abort flags", {29'd0, bus.isNotEqual, bus.isLessThan,
            bus.overflow}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("abort in_ready", 32'(bus.in_ready), 32'd1);
        repeat (25) @(negedge clock);
        chk("abort stays idle", 32'(bus.out_valid), 32'd0);

        runOp("op zero", 6'b000000, 32'd5, 32'd5, 5'd0,
              32'd0, 0, 0, 0, 0);
        runOp("multi-hot", 6'b000011, 32'd3, 32'd3, 5'd0,
              32'd6, 0, 0, 0, 0);
        runOp("sll 0", 6'b010000, 32'h12345678, 32'h00000000, 5'd0,
              32'h12345678, 1, 0, 0, 0);

        repeat (3) @(negedge clock);
        chk("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
